// File: rtl/safety_obi_mem_pkg.sv
// Shared types and helpers for the OBI-to-SRAM responder.
package safety_obi_mem_pkg;

    localparam int unsigned MaxSramLatency      = 3;
    localparam int unsigned MaxOutstandingLimit = 4;

    // Per-transaction metadata travelling alongside the SRAM access.
    typedef struct packed {
        logic valid;
        logic err;
        logic we;
    } resp_meta_t;

    // Byte offset of an address inside the bank; wraps for addresses below base.
    function automatic logic [31:0] word_offset(input logic [31:0] addr,
                                                input logic [31:0] base);
        return addr - base;
    endfunction

endpackage

// File: rtl/safety_obi_resp_pipe.sv
// Fixed-length delay line of response metadata, matched to the SRAM read latency.
module safety_obi_resp_pipe
    import safety_obi_mem_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  resp_meta_t meta_i,
    output resp_meta_t meta_o
);

    resp_meta_t [Depth-1:0] stage_q;
    resp_meta_t [Depth-1:0] stage_d;

    // Shift every cycle; stage 0 takes the freshly accepted transaction.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = meta_i;
        for (int unsigned i = 1; i < Depth; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Synchronous clear drops every in-flight response.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign meta_o = stage_q[Depth-1];

endmodule

// File: rtl/safety_obi_mem_responder.sv
// OBI responder for one core memory port in front of a single-port SRAM bank.
// Responses return in order at a fixed SRAM latency; out-of-range accesses are
// answered with an error and never reach the SRAM.
module safety_obi_mem_responder
    import safety_obi_mem_pkg::*;
#(
    parameter logic [31:0] BaseAddr       = 32'h0000_0000,
    parameter int unsigned MemSizeBytes   = 65536,
    parameter int unsigned SramLatency    = 1,
    parameter int unsigned MaxOutstanding = 2,
    parameter int unsigned SramAddrWidth  = $clog2(MemSizeBytes / 4)
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     req_i,
    output logic                     gnt_o,
    input  logic [31:0]              addr_i,
    input  logic                     we_i,
    input  logic [3:0]               be_i,
    input  logic [31:0]              wdata_i,
    output logic                     rvalid_o,
    output logic [31:0]              rdata_o,
    output logic                     err_o,
    output logic                     sram_req_o,
    input  logic                     sram_gnt_i,
    output logic                     sram_we_o,
    output logic [3:0]               sram_be_o,
    output logic [SramAddrWidth-1:0] sram_addr_o,
    output logic [31:0]              sram_wdata_o,
    input  logic [31:0]              sram_rdata_i
);

    localparam int unsigned CntWidth = $clog2(MaxOutstandingLimit + 1);
    localparam logic [31:0] MemSize  = 32'(MemSizeBytes);

    logic [31:0]         offset;
    logic                in_range;
    logic                credit;
    logic                accept;
    logic [CntWidth-1:0] outstanding_q;
    logic [CntWidth-1:0] outstanding_d;
    logic [CntWidth-1:0] outstanding_eff;
    resp_meta_t          meta_in;
    resp_meta_t          meta_out;

    // Address decode: unsigned wrap makes addresses below the base out of range.
    always_comb begin
        offset   = word_offset(addr_i, BaseAddr);
        in_range = offset < MemSize;
    end

    // Handshake: a retiring response frees its slot in the same cycle.
    always_comb begin
        outstanding_eff = outstanding_q - CntWidth'(rvalid_o);
        credit          = outstanding_eff < CntWidth'(MaxOutstanding);
        gnt_o           = rst_ni & req_i & credit & (in_range ? sram_gnt_i : 1'b1);
        sram_req_o      = rst_ni & req_i & in_range & credit;
        accept          = req_i & gnt_o;
    end

    assign sram_addr_o  = offset[SramAddrWidth+1:2];
    assign sram_we_o    = we_i;
    assign sram_be_o    = be_i;
    assign sram_wdata_o = wdata_i;

    // Metadata entering the response pipeline this cycle.
    always_comb begin
        meta_in       = '0;
        meta_in.valid = accept;
        meta_in.err   = accept & ~in_range;
        meta_in.we    = accept & we_i;
    end

    safety_obi_resp_pipe #(
        .Depth (SramLatency)
    ) u_resp_pipe (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .meta_i (meta_in),
        .meta_o (meta_out)
    );

    // Response phase: only clean reads carry SRAM data.
    always_comb begin
        rvalid_o = meta_out.valid;
        err_o    = meta_out.valid & meta_out.err;
        rdata_o  = (meta_out.valid && !meta_out.err && !meta_out.we) ? sram_rdata_i : '0;
    end

    // Outstanding count next state: simultaneous accept and retire cancel out.
    always_comb begin
        outstanding_d = outstanding_q;
        case ({accept, rvalid_o})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Outstanding count register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            outstanding_q <= '0;
        end else begin
            outstanding_q <= outstanding_d;
        end
    end

`ifndef SYNTHESIS
    outstanding_bound_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        outstanding_q <= CntWidth'(MaxOutstanding));
`endif

endmodule

// File: tb/tb_safety_obi_mem_responder.sv
// Randomized bench for safety_obi_mem_responder with a transaction-level model.
module tb_safety_obi_mem_responder;

    localparam logic [31:0] Base  = 32'h0000_1000;
    localparam int unsigned Size  = 256;
    localparam int unsigned Lat   = 3;
    localparam int unsigned MaxO  = 2;
    localparam int unsigned Aw    = 6;
    localparam int unsigned Words = 64;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req = 1'b0;
    logic          gnt;
    logic [31:0]   addr = '0;
    logic          we = 1'b0;
    logic [3:0]    be = '0;
    logic [31:0]   wdata = '0;
    logic          rvalid;
    logic [31:0]   rdata;
    logic          err;
    logic          sram_req;
    logic          sram_gnt = 1'b1;
    logic          sram_we;
    logic [3:0]    sram_be;
    logic [Aw-1:0] sram_addr;
    logic [31:0]   sram_wdata;
    logic [31:0]   sram_rdata = '0;

    safety_obi_mem_responder #(
        .BaseAddr       (Base),
        .MemSizeBytes   (Size),
        .SramLatency    (Lat),
        .MaxOutstanding (MaxO)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_i        (req),
        .gnt_o        (gnt),
        .addr_i       (addr),
        .we_i         (we),
        .be_i         (be),
        .wdata_i      (wdata),
        .rvalid_o     (rvalid),
        .rdata_o      (rdata),
        .err_o        (err),
        .sram_req_o   (sram_req),
        .sram_gnt_i   (sram_gnt),
        .sram_we_o    (sram_we),
        .sram_be_o    (sram_be),
        .sram_addr_o  (sram_addr),
        .sram_wdata_o (sram_wdata),
        .sram_rdata_i (sram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          err;
        bit          we;
        logic [31:0] data;
    } resp_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;

    resp_t       pend[$];    // model: accepted transactions awaiting their response
    rd_t         rd_q[$];    // SRAM emulation: read data in flight
    logic [31:0] mem_m[Words];
    logic [31:0] sram_mem[Words];

    int          n_total = 0;
    int          n_pass = 0;
    int          cyc = 0;

    logic        e_gnt;
    logic        m_inr;
    logic [31:0] m_off;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare every DUT output against the transaction-level model for this cycle.
    task automatic model_compare();
        int          live;
        bit          e_rv;
        bit          e_err;
        logic [31:0] e_rd;
        bit          credit;
        live = 0;
        e_rv = 0;
        e_err = 0;
        e_rd = '0;
        foreach (pend[i]) begin
            if (pend[i].due > cyc) live++;
            if (pend[i].due == cyc) begin
                e_rv  = 1;
                e_err = pend[i].err;
                e_rd  = (pend[i].err || pend[i].we) ? 32'h0 : pend[i].data;
            end
        end
        credit = live < MaxO;
        m_off  = addr - Base;
        m_inr  = m_off < Size;
        e_gnt  = rst_n & req & credit & (m_inr ? sram_gnt : 1'b1);
        chk("gnt", gnt, e_gnt);
        chk("sram_req", sram_req, rst_n & req & m_inr & credit);
        chk("sram_addr", sram_addr, m_off[Aw+1:2]);
        chk("sram_we", sram_we, we);
        chk("sram_be", sram_be, be);
        chk("sram_wdata", sram_wdata, wdata);
        chk("rvalid", rvalid, e_rv);
        chk("err", err, e_err);
        chk("rdata", rdata, e_rd);
    endtask

    task automatic begin_cycle(input bit r, input bit q, input logic [31:0] a, input bit w,
                               input logic [3:0] b, input logic [31:0] d, input bit sg);
        rst_n    = r;
        req      = q;
        addr     = a;
        we       = w;
        be       = b;
        wdata    = d;
        sram_gnt = sg;
        while (rd_q.size() > 0 && rd_q[0].due < cyc) void'(rd_q.pop_front());
        if (rd_q.size() > 0 && rd_q[0].due == cyc) begin
            sram_rdata = rd_q[0].data;
            void'(rd_q.pop_front());
        end else begin
            sram_rdata = $urandom;
        end
        #3;
        model_compare();
    endtask

    // Advance SRAM emulation and the model across the clock edge.
    task automatic end_cycle();
        if (sram_req && sram_gnt) begin
            if (sram_we) begin
                sram_mem[sram_addr] = merge(sram_mem[sram_addr], sram_wdata, sram_be);
            end else begin
                rd_q.push_back('{due: cyc + Lat, data: sram_mem[sram_addr]});
            end
        end
        if (!rst_n) begin
            pend.delete();
        end else begin
            while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
            if (e_gnt) begin
                pend.push_back('{due: cyc + Lat, err: !m_inr, we: we,
                                 data: (m_inr && !we) ? mem_m[m_off[Aw+1:2]] : 32'h0});
                if (m_inr && we) mem_m[m_off[Aw+1:2]] = merge(mem_m[m_off[Aw+1:2]], wdata, be);
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        begin_cycle(1, 0, 32'h0, 0, 4'h0, 32'h0, 1);
    endtask

    logic [31:0] oor_addr;
    bit          hold;
    int          grants;

    initial begin
        for (int i = 0; i < Words; i++) begin
            mem_m[i]    = $urandom;
            sram_mem[i] = mem_m[i];
        end
        mem_m[4]    = 32'hDEAD_BEEF;
        sram_mem[4] = 32'hDEAD_BEEF;

        // First edge clears the DUT; nothing is defined before it.
        rst_n = 1'b0;
        @(posedge clk);
        #1;

        // Reset holds off a live request.
        for (int i = 0; i < 2; i++) begin
            begin_cycle(0, 1, Base + 32'h10, 0, 4'hF, 32'h0, 1);
            chk("rst_gnt", gnt, 0);
            chk("rst_sram_req", sram_req, 0);
            chk("rst_rvalid", rvalid, 0);
            chk("rst_rdata", rdata, 0);
            end_cycle();
        end

        // Single read of word 4.
        begin_cycle(1, 1, Base + 32'h10, 0, 4'hF, 32'h0, 1);
        chk("single_gnt", gnt, 1);
        chk("single_sram_addr", sram_addr, 4);
        end_cycle();
        idle(); end_cycle();
        idle(); end_cycle();
        idle();
        chk("single_rvalid", rvalid, 1);
        chk("single_rdata", rdata, 32'hDEAD_BEEF);
        chk("single_err", err, 0);
        end_cycle();

        // Continuous requests: two slots against three cycles of latency.
        grants = 0;
        for (int i = 0; i < 6; i++) begin
            begin_cycle(1, 1, Base + 32'h20, 0, 4'hF, 32'h0, 1);
            grants += int'(gnt);
            end_cycle();
        end
        chk("throttle_grants", grants, 4);
        for (int i = 0; i < 3; i++) begin idle(); end_cycle(); end

        // Out-of-range write above the bank and read below it.
        begin_cycle(1, 1, Base + Size, 1, 4'hF, 32'h1234_5678, 0);
        chk("oor_wr_gnt", gnt, 1);
        chk("oor_wr_sram_req", sram_req, 0);
        end_cycle();
        begin_cycle(1, 1, Base - 4, 0, 4'hF, 32'h0, 0);
        chk("oor_rd_gnt", gnt, 1);
        chk("oor_rd_sram_req", sram_req, 0);
        end_cycle();
        idle(); end_cycle();
        for (int i = 0; i < 2; i++) begin
            idle();
            chk("oor_rvalid", rvalid, 1);
            chk("oor_err", err, 1);
            chk("oor_rdata", rdata, 0);
            end_cycle();
        end

        // SRAM stall for three cycles, then accepted.
        for (int i = 0; i < 3; i++) begin
            begin_cycle(1, 1, Base + 32'h10, 0, 4'hF, 32'h0, 0);
            chk("stall_gnt", gnt, 0);
            end_cycle();
        end
        begin_cycle(1, 1, Base + 32'h10, 0, 4'hF, 32'h0, 1);
        chk("stall_release_gnt", gnt, 1);
        end_cycle();
        idle(); end_cycle();
        idle(); end_cycle();
        idle();
        chk("stall_rvalid", rvalid, 1);
        chk("stall_rdata", rdata, 32'hDEAD_BEEF);
        end_cycle();

        // Reset with two reads in flight.
        begin_cycle(1, 1, Base + 32'h10, 0, 4'hF, 32'h0, 1); end_cycle();
        begin_cycle(1, 1, Base + 32'h14, 0, 4'hF, 32'h0, 1); end_cycle();
        begin_cycle(0, 0, 32'h0, 0, 4'h0, 32'h0, 1); end_cycle();
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("flush_rvalid", rvalid, 0);
            end_cycle();
        end
        for (int i = 0; i < 2; i++) begin
            begin_cycle(1, 1, Base + 32'h18, 0, 4'hF, 32'h0, 1);
            chk("post_rst_gnt", gnt, 1);
            end_cycle();
        end
        for (int i = 0; i < 4; i++) begin idle(); end_cycle(); end

        // Randomized traffic; a refused request is held until granted.
        hold = 0;
        for (int n = 0; n < 3000; n++) begin
            logic        r_rst;
            logic        r_req;
            logic [31:0] r_addr;
            logic        r_we;
            logic [3:0]  r_be;
            logic [31:0] r_wd;
            r_rst = ($urandom_range(0, 63) != 0);
            if (hold) begin
                r_req  = req;
                r_addr = addr;
                r_we   = we;
                r_be   = be;
                r_wd   = wdata;
            end else begin
                r_req = ($urandom_range(0, 3) != 0);
                if ($urandom_range(0, 4) != 0) begin
                    r_addr = Base + $urandom_range(0, Size - 1);
                end else begin
                    case ($urandom_range(0, 3))
                        0:       oor_addr = Base - 4;
                        1:       oor_addr = Base + Size;
                        2:       oor_addr = Base + Size + $urandom_range(0, 1000);
                        default: oor_addr = 32'hFFFF_FFFC;
                    endcase
                    r_addr = oor_addr;
                end
                r_we = $urandom_range(0, 1) != 0;
                r_be = 4'($urandom);
                r_wd = $urandom;
            end
            begin_cycle(r_rst, r_req, r_addr, r_we, r_be, r_wd, $urandom_range(0, 3) != 0);
            hold = req && !gnt;
            end_cycle();
        end
        for (int i = 0; i < Lat + 1; i++) begin idle(); end_cycle(); end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
